// File: rtl/matrix_encoder_reg_arbiter.sv
// Two-requester round-robin AXI4-Lite master for the MatrixEncoder register
// slave (four 32-bit registers at 0x0, 0x4, 0x8, 0xC).
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   reqN_valid/ready      command handshake; ready is a one-cycle grant pulse
//   reqN_write/addr/wdata command fields, held stable until reqN_ready
//   rspN_valid            one-cycle completion pulse for requester N
//   rsp_rdata, rsp_resp   data/response of the last completion (held)
//   busy                  high whenever a transaction is in flight
//   err_count             saturating count of non-OKAY responses
//   M_AXI_*               AXI4-Lite master towards the encoder S00_AXI port
module matrix_encoder_reg_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_ERR_CNT_WIDTH  = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESET,

    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic                        req0_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0] req0_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0] req0_wdata,

    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic                        req1_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0] req1_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0] req1_wdata,

    output logic                        rsp0_valid,
    output logic                        rsp1_valid,
    output logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        busy,
    output logic [C_ERR_CNT_WIDTH-1:0]  err_count,

    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                  M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int EW = C_ERR_CNT_WIDTH;

    // Registers are word-aligned; byte offset bits are always driven as 0.
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};
    localparam logic [EW-1:0] ERR_ONE    = {{(EW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic [EW-1:0]   err_q, err_d;

    logic            grant_any;
    logic            pick1;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            aw_done;
    logic            w_done;
    logic            done;
    logic [1:0]      done_resp;

    // req1 wins when it is alone, or on a tie when req0 was granted last
    // (last_q = 0 means req0 held the previous grant).
    assign pick1     = req1_valid & (~req0_valid | ~last_q);
    assign grant_any = (state_q == S_IDLE) & ~ARESET
                     & (req0_valid | req1_valid);

    assign req0_ready = grant_any & ~pick1;
    assign req1_ready = grant_any & pick1;

    assign sel_write = pick1 ? req1_write : req0_write;
    assign sel_addr  = pick1 ? req1_addr  : req0_addr;
    assign sel_wdata = pick1 ? req1_wdata : req0_wdata;

    // A channel counts as done once its VALID has dropped or it handshakes now.
    assign aw_done = ~awvalid_q | M_AXI_AWREADY;
    assign w_done  = ~wvalid_q  | M_AXI_WREADY;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 2'b00;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        err_d       = err_q;
        done        = 1'b0;
        done_resp   = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    gnt_d   = pick1;
                    last_d  = pick1;
                    addr_d  = sel_addr & ALIGN_MASK;
                    wdata_d = sel_wdata;
                    if (sel_write) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    state_d   = S_IDLE;
                    bready_d  = 1'b0;
                    rdata_d   = '0;
                    resp_d    = M_AXI_BRESP;
                    done      = 1'b1;
                    done_resp = M_AXI_BRESP;
                end
            end
            S_READ: begin
                if (M_AXI_ARREADY) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RDATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    state_d   = S_IDLE;
                    rready_d  = 1'b0;
                    rdata_d   = M_AXI_RDATA;
                    resp_d    = M_AXI_RRESP;
                    done      = 1'b1;
                    done_resp = M_AXI_RRESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done) begin
            rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
            if (done_resp != 2'b00 && err_q != {EW{1'b1}}) begin
                err_d = err_q + ERR_ONE;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rdata_q     <= '0;
            resp_q      <= 2'b00;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
        end
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp_rdata  = rdata_q;
    assign rsp_resp   = resp_q;
    assign busy       = (state_q != S_IDLE);
    assign err_count  = err_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_matrix_encoder_reg_arbiter.sv
// Bench for matrix_encoder_reg_arbiter: AXI4-Lite register slave model,
// requester drivers, and a scoreboard of expected completions.
`timescale 1ns/1ps
module tb_matrix_encoder_reg_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [3:0]  req0_addr = '0;
    logic [31:0] req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [3:0]  req1_addr = '0;
    logic [31:0] req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY;
    logic        M_AXI_ARVALID, M_AXI_RREADY;
    logic [31:0] M_AXI_WDATA;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0;
    logic        M_AXI_BVALID = 1'b0, M_AXI_ARREADY = 1'b0;
    logic        M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = '0;

    matrix_encoder_reg_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .err_count(err_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          r;
        bit          wr;
        logic [31:0] d;
        logic [1:0]  resp;
    } exp_t;

    exp_t        expq[$];
    int          grant_log[$];
    logic [31:0] model_mem[4];
    logic [31:0] smem[4];
    int          model_err = 0;
    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          writes_done = 0, b_count = 0;
    logic [1:0]  resp_cfg = 2'b00;
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // Scoreboard entry is created the moment a grant is observed.
    task automatic record_grant(input int r, input logic wr,
                                input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        grant_log.push_back(r);
        e.r = r;
        e.wr = wr;
        e.resp = resp_cfg;
        if (wr) begin
            model_mem[a[3:2]] = d;
            e.d = 32'h0;
        end else begin
            e.d = model_mem[a[3:2]];
        end
        expq.push_back(e);
    endtask

    task automatic issue(input int r, input logic wr, input logic [3:0] a,
                         input logic [31:0] d, output int gcyc);
        bit got = 0;
        gcyc = -1;
        @(negedge ACLK);
        if (r == 0) begin
            req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
        for (int i = 0; i < 300 && !got; i++) begin
            #1;
            if ((r == 0) ? req0_ready : req1_ready) begin
                got = 1;
                gcyc = cyc;
                record_grant(r, wr, a, d);
            end else begin
                @(negedge ACLK);
            end
        end
        if (!got) fail_now($sformatf("grant_timeout r=%0d", r));
        @(posedge ACLK);
        #1;
        if (r == 0) req0_valid = 0;
        else req1_valid = 0;
    endtask

    task automatic wait_rsp(input int r, output logic [31:0] d,
                            output logic [1:0] rs, output int rc);
        bit got = 0;
        d = 0; rs = 0; rc = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge ACLK);
            #1;
            if ((r == 0) ? rsp0_valid : rsp1_valid) begin
                got = 1; d = rsp_rdata; rs = rsp_resp; rc = cyc;
            end
        end
        if (!got) fail_now($sformatf("rsp_timeout r=%0d", r));
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 1000) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 1000) fail_now("drain_timeout");
        @(negedge ACLK);
    endtask

    // AXI4-Lite register slave with programmable per-channel stalls.
    initial begin : slave
        bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        bit aw_got = 0, w_got = 0, b_pending = 0, r_pending = 0;
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_wait = 0, r_wait = 0;
        logic [3:0]  aw_lat = 0, aw_a = 0, ar_lat = 0, ar_a = 0;
        logic [31:0] w_lat = 0, w_d = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
            end else begin
                if (aw_hs) begin
                    aw_got = 1; aw_a = aw_lat; aw_cnt = 0;
                    check("awvalid_drop", M_AXI_AWVALID, 0);
                end
                if (w_hs) begin
                    w_got = 1; w_d = w_lat; w_cnt = 0;
                    check("wvalid_drop", M_AXI_WVALID, 0);
                end
                if (b_hs) begin
                    b_count++; b_pending = 0;
                end
                if (ar_hs) begin
                    r_pending = 1; r_wait = 0; ar_a = ar_lat; ar_cnt = 0;
                end
                if (r_hs) r_pending = 0;
                if (aw_got && w_got) begin
                    smem[aw_a[3:2]] = w_d;
                    aw_got = 0; w_got = 0; b_pending = 1; b_wait = 0;
                end
                if (M_AXI_BREADY) check("bready_after_both", b_pending, 1);

                M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
                if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
                aw_lat = M_AXI_AWADDR;
                M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_dly);
                if (M_AXI_WVALID && !M_AXI_WREADY) w_cnt++;
                w_lat = M_AXI_WDATA;
                M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
                if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_cnt++;
                ar_lat = M_AXI_ARADDR;

                M_AXI_BVALID = b_pending && (b_wait >= b_dly);
                if (b_pending && !M_AXI_BVALID) b_wait++;
                M_AXI_BRESP = resp_cfg;
                M_AXI_RVALID = r_pending && (r_wait >= r_dly);
                if (r_pending && !M_AXI_RVALID) r_wait++;
                M_AXI_RDATA = M_AXI_RVALID ? smem[ar_a[3:2]] : 32'hDEADBEEF;
                M_AXI_RRESP = resp_cfg;

                aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
                w_hs  = M_AXI_WVALID && M_AXI_WREADY;
                b_hs  = M_AXI_BVALID && M_AXI_BREADY;
                ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
                r_hs  = M_AXI_RVALID && M_AXI_RREADY;
            end
        end
    end

    // Per-cycle comparison of the DUT against the scoreboard.
    initial begin : compare
        bit   prev_rsp = 0;
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                expq.delete();
                model_err = 0;
                prev_rsp = 0;
                check("reset_ctl",
                      {busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                       M_AXI_ARVALID, M_AXI_RREADY, rsp0_valid, rsp1_valid,
                       err_count}, 0);
                check("reset_data",
                      {rsp_resp, rsp_rdata, M_AXI_AWADDR, M_AXI_ARADDR}, 0);
                check("reset_wdata", M_AXI_WDATA, 0);
            end else begin
                if (rsp0_valid || rsp1_valid) begin
                    check("rsp_both", rsp0_valid && rsp1_valid, 0);
                    check("rsp_one_cycle", prev_rsp, 0);
                    if (expq.size() == 0) begin
                        fail_now("unexpected_rsp");
                    end else begin
                        e = expq.pop_front();
                        check("rsp_who", rsp1_valid, e.r[0]);
                        check("rsp_rdata", rsp_rdata, e.d);
                        check("rsp_resp", rsp_resp, e.resp);
                        if (e.resp != 2'b00 && model_err < 255) model_err++;
                        if (e.wr) writes_done++;
                    end
                end
                prev_rsp = rsp0_valid || rsp1_valid;
                check("err_count", err_count, model_err);
                if (M_AXI_AWVALID)
                    check("aw_attr", {M_AXI_AWPROT, M_AXI_AWADDR[1:0]}, 0);
                if (M_AXI_WVALID)
                    check("wstrb", M_AXI_WSTRB, 4'hF);
                if (M_AXI_ARVALID)
                    check("ar_attr", {M_AXI_ARPROT, M_AXI_ARADDR[1:0]}, 0);
                if (M_AXI_ARVALID || M_AXI_RREADY)
                    check("one_txn",
                          {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);
            end
        end
    end

    initial begin : stim
        int          g, rc, b0;
        logic [31:0] d;
        logic [1:0]  rs;
        logic [5:0]  gv;
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = 0;
            smem[i] = 0;
        end
        repeat (3) @(negedge ACLK);
        #1 ARESET = 0;

        // Single write: grant at T, AW/W at T+1, B at T+2, rsp at T+3.
        @(negedge ACLK);
        req0_valid = 1; req0_write = 1; req0_addr = 4'h4;
        req0_wdata = 32'h2;
        #1;
        check("t1_ready", req0_ready, 1);
        if (req0_ready) record_grant(0, 1, 4'h4, 32'h2);
        @(posedge ACLK);
        #1 req0_valid = 0;
        @(negedge ACLK);
        check("t1_aw",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WSTRB,
               M_AXI_WDATA},
              {1'b1, 1'b1, 4'h4, 4'hF, 32'h2});
        @(negedge ACLK);
        check("t1_bready", M_AXI_BREADY, 1);
        @(negedge ACLK);
        check("t1_rsp", {rsp0_valid, rsp_resp, err_count},
              {1'b1, 2'b00, 8'h00});
        drain();

        // req1 fills all four registers then reads them back.
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 4'(i * 4), 32'(i + 1), g);
            wait_rsp(1, d, rs, rc);
            check("t2_wr_resp", rs, 0);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 4'(i * 4), 32'h0, g);
            wait_rsp(1, d, rs, rc);
            check("t2_rd", d, 32'(i + 1));
        end
        issue(1, 1, 4'hE, 32'h55, g);
        wait_rsp(1, d, rs, rc);
        issue(1, 0, 4'hD, 32'h0, g);
        wait_rsp(1, d, rs, rc);
        check("t2_unaligned", d, 32'h55);
        drain();

        // Both requesters keep reads pending: grants must alternate.
        grant_log.delete();
        fork
            begin
                int g0;
                for (int k = 0; k < 3; k++) issue(0, 0, 4'(k * 4), 0, g0);
            end
            begin
                int g1;
                for (int k = 0; k < 3; k++) issue(1, 0, 4'(k * 4 + 4), 0, g1);
            end
        join
        drain();
        gv = '0;
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) gv[i] = grant_log[i][0];
        check("t3_grants", {8'(grant_log.size()), gv}, {8'd6, 6'b101010});

        // W accepted three cycles before AW, then the reverse.
        b0 = b_count;
        aw_dly = 3; w_dly = 0;
        issue(0, 1, 4'h8, 32'hA5, g);
        wait_rsp(0, d, rs, rc);
        check("t4a_lat", rc - g, 6);
        aw_dly = 0; w_dly = 3;
        issue(1, 1, 4'h8, 32'h5A, g);
        wait_rsp(1, d, rs, rc);
        check("t4b_lat", rc - g, 6);
        aw_dly = 0; w_dly = 0;
        drain();
        check("t4_b_count", b_count - b0, 2);
        issue(0, 0, 4'h8, 32'h0, g);
        wait_rsp(0, d, rs, rc);
        check("t4_rd", d, 32'h5A);

        // SLVERR on every read: error counter saturates.
        resp_cfg = 2'b10;
        for (int i = 0; i < 300; i++) begin
            issue(1, 0, 4'h0, 32'h0, g);
            wait_rsp(1, d, rs, rc);
        end
        check("t5_resp", rs, 2'b10);
        check("t5_err_sat", err_count, 8'hFF);
        resp_cfg = 2'b00;
        drain();

        // Reset while waiting for B: transaction is dropped silently.
        b_dly = 5;
        issue(0, 1, 4'hC, 32'h77, g);
        @(negedge ACLK);
        @(negedge ACLK);
        check("t6_in_wresp", {busy, M_AXI_BREADY, M_AXI_BVALID},
              {1'b1, 1'b1, 1'b0});
        #1 ARESET = 1;
        @(negedge ACLK);
        check("t6_after", {busy, M_AXI_BREADY, rsp0_valid, err_count}, 0);
        #1 ARESET = 0;
        b_dly = 0;
        repeat (4) @(negedge ACLK);
        issue(0, 0, 4'hC, 32'h0, g);
        check("t6_grant", (g >= 0), 1);
        wait_rsp(0, d, rs, rc);
        check("t6_rd", d, 32'h77);
        drain();

        check("b_total", b_count, writes_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_encoder_reg_arbiter.md
Name: matrix_encoder_reg_arbiter

Overview:
Two-requester AXI4-Lite master that shares the MatrixEncoder register slave (four 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC).
Each requester issues single-word read or write commands on a simple valid/ready port.
The block arbitrates round-robin, runs one AXI4-Lite transaction at a time, and returns read data and response to the granted requester.
It sits between the control logic (sequencer, debug host) and the encoder's S00_AXI port.

Parameters:
C_AXI_ADDR_WIDTH, 4, AXI4-Lite address width; covers 4 registers.
C_AXI_DATA_WIDTH, 32, data width; only 32 supported.
C_ERR_CNT_WIDTH, 8, width of saturating error counter.

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous reset, active-high
req0_valid / req1_valid  in  1  command request
req0_ready / req1_ready  out  1  one-cycle grant/accept pulse
req0_write / req1_write  in  1  1 = write, 0 = read
req0_addr / req1_addr  in  C_AXI_ADDR_WIDTH  byte address
req0_wdata / req1_wdata  in  32  write data
rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  read data (0 for writes); valid with rspN_valid
rsp_resp  out  2  BRESP/RRESP of completed transaction
busy  out  1  high whenever state != IDLE
err_count  out  C_ERR_CNT_WIDTH  count of non-OKAY responses, saturating
M_AXI_AWADDR out C_AXI_ADDR_WIDTH; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1
M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
M_AXI_ARADDR out C_AXI_ADDR_WIDTH; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1

Behaviour:
- Reset (ARESET high at a clock edge): state = IDLE.
  - All *VALID, BREADY, RREADY, reqN_ready, rspN_valid and busy = 0.
  - rsp_rdata = 0, rsp_resp = 0, err_count = 0; AxADDR and WDATA = 0.
  - Last-grant pointer = 1, so req0 wins the first tie.
- Reset mid-transaction: all outputs return to reset values on the next edge. The in-flight transaction is abandoned and no rsp is issued.
- Constants: AWPROT = ARPROT = 3'b000, WSTRB = 4'hF. AxADDR[1:0] is forced to 0; the upper address bits pass through.
- Requester rule: reqN_valid and the command fields are held stable until reqN_ready. A requester may drop valid before grant; no grant then follows.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA.
- IDLE:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester not granted last.
  - In the grant cycle, reqN_ready pulses for one cycle, the command is captured, and the pointer is updated.
  - The next state is WRITE or READ.
  - If neither valid is high, stay in IDLE.
- WRITE:
  - On entry, AWVALID = WVALID = 1.
  - Each VALID drops in the cycle after its own handshake; AW and W complete independently in either order or together.
  - When both have completed, go to WRESP with BREADY = 1.
- WRESP: on BVALID & BREADY, the next cycle has BREADY = 0, rspN_valid = 1, rsp_resp = BRESP, rsp_rdata = 0, state = IDLE.
- READ: ARVALID = 1 until ARREADY is sampled, then go to RDATA with RREADY = 1.
- RDATA: on RVALID & RREADY, the next cycle has RREADY = 0, rspN_valid = 1, rsp_rdata = RDATA, rsp_resp = RRESP, state = IDLE.
- rsp_rdata and rsp_resp hold their values until the next completion.
- A new grant may occur in the same cycle as rspN_valid, since the state is already IDLE.
- Latency with an always-ready slave and the response one cycle after the address:
  - Grant at T, AW/W or AR at T+1, B/R at T+2, rsp at T+3.
  - The next grant is at T+3.
- err_count increments by 1 on each completion with resp != 2'b00 and saturates at all-ones.
- No outstanding transactions: at most one AXI transaction is active at a time.

Test Plan:
- req0 write addr 0x4, data 0x00000002, slave always ready, BRESP = OKAY -> req0_ready at T, AW/W at T+1 with AWADDR 0x4 and WSTRB 0xF, rsp0_valid at T+3, rsp_resp = 0, err_count = 0.
- Write 0x1, 0x2, 0x3, 0x4 to addresses 0x0–0xC via req1, then read them back -> rsp_rdata returns 0x1..0x4 in order, each rsp1_valid exactly one cycle.
- Both requesters hold reads continuously for 6 commands -> grants alternate 0, 1, 0, 1, 0, 1 and each rspN_valid goes to the matching requester.
- WREADY asserted 3 cycles before AWREADY, then the reverse case -> WVALID drops after its own handshake, BREADY rises only after both handshakes, exactly one B accepted.
- Slave returns RRESP = 2'b10 on 300 reads -> rsp_resp = 2, err_count saturates at 255.
- ARESET pulsed while in WRESP with BVALID low -> next cycle busy = 0, all VALID/READY outputs 0, no rsp pulse, err_count = 0, next req0 grant proceeds normally.
